// File: rtl/acc_bank_if.sv
// Command/readback bundle for acc_bank: command handshake, operands, read select and status.
interface acc_bank_if #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
);
    localparam int SELW = $clog2(DEPTH);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [SELW-1:0] wr_sel;
    logic [SIZE-1:0] in_val;
    logic [SELW-1:0] rd_sel;
    logic [SIZE-1:0] out_val;
    logic            carry_flag;
    logic            zero_flag;
    logic            busy;

    modport master (
        output in_valid, op, wr_sel, in_val, rd_sel,
        input  in_ready, out_val, carry_flag, zero_flag, busy
    );

    modport slave (
        input  in_valid, op, wr_sel, in_val, rd_sel,
        output in_ready, out_val, carry_flag, zero_flag, busy
    );
endinterface

// File: rtl/acc_bank.sv
// Bank of DEPTH accumulators with single-cycle ALU ops and an iterative shift-add multiplier.
//   state   | meaning
//   ST_IDLE | accepting commands, single-cycle ops write at the accepting edge
//   ST_MUL  | shift-add in progress, one multiplier bit per cycle, commands ignored
module acc_bank #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input logic        clk,
    input logic        rst,
    acc_bank_if.slave  bus
);
    localparam int SELW = $clog2(DEPTH);
    localparam int CW   = $clog2(SIZE);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t            state;
    logic [SIZE-1:0]   acc [DEPTH];
    logic              carry;
    logic              zero;
    logic [CW-1:0]     cnt;
    logic [2*SIZE-1:0] mcand;
    logic [2*SIZE-1:0] prod;
    logic [2*SIZE-1:0] prod_nxt;
    logic [SIZE-1:0]   mplier;
    logic [SELW-1:0]   tgt;

    logic [SIZE-1:0]   cur;
    logic [SIZE:0]     sum;
    logic [SIZE:0]     diff;
    logic [SIZE-1:0]   add_res;
    logic [SIZE-1:0]   sub_res;
    logic [SIZE-1:0]   and_res;
    logic [SIZE-1:0]   or_res;
    logic [SIZE-1:0]   xor_res;

    assign cur      = acc[bus.wr_sel];
    assign sum      = {1'b0, cur} + {1'b0, bus.in_val};
    // bit SIZE of the extended difference is the borrow
    assign diff     = {1'b0, cur} - {1'b0, bus.in_val};
    assign add_res  = (SAT != 0 && sum[SIZE])  ? '1 : sum[SIZE-1:0];
    assign sub_res  = (SAT != 0 && diff[SIZE]) ? '0 : diff[SIZE-1:0];
    assign and_res  = cur & bus.in_val;
    assign or_res   = cur | bus.in_val;
    assign xor_res  = cur ^ bus.in_val;
    assign prod_nxt = mplier[0] ? prod + mcand : prod;

    assign bus.out_val    = acc[bus.rd_sel];
    assign bus.carry_flag = carry;
    assign bus.zero_flag  = zero;
    assign bus.busy       = (state == ST_MUL);
    assign bus.in_ready   = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            state  <= ST_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            tgt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        case (bus.op)
                            OP_NOP: ;
                            OP_LOAD: begin
                                acc[bus.wr_sel] <= bus.in_val;
                                zero            <= (bus.in_val == '0);
                            end
                            OP_ADD: begin
                                acc[bus.wr_sel] <= add_res;
                                carry           <= sum[SIZE];
                                zero            <= (add_res == '0);
                            end
                            OP_SUB: begin
                                acc[bus.wr_sel] <= sub_res;
                                carry           <= diff[SIZE];
                                zero            <= (sub_res == '0);
                            end
                            OP_AND: begin
                                acc[bus.wr_sel] <= and_res;
                                zero            <= (and_res == '0);
                            end
                            OP_OR: begin
                                acc[bus.wr_sel] <= or_res;
                                zero            <= (or_res == '0);
                            end
                            OP_XOR: begin
                                acc[bus.wr_sel] <= xor_res;
                                zero            <= (xor_res == '0);
                            end
                            OP_MUL: begin
                                mcand  <= {{SIZE{1'b0}}, cur};
                                mplier <= bus.in_val;
                                prod   <= '0;
                                tgt    <= bus.wr_sel;
                                cnt    <= CW'(SIZE - 1);
                                state  <= ST_MUL;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    // last iteration folds its partial product straight into the write
                    if (cnt == '0) begin
                        acc[tgt] <= prod_nxt[SIZE-1:0];
                        carry    <= |prod_nxt[2*SIZE-1:SIZE];
                        zero     <= (prod_nxt[SIZE-1:0] == '0);
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank: a wrap (SAT=0) and a saturating (SAT=1) instance see the same commands.
module tb_acc_bank;
    logic clk;
    logic rst;

    acc_bank_if #(.SIZE(8), .DEPTH(4)) bus0 ();
    acc_bank_if #(.SIZE(8), .DEPTH(4)) bus1 ();

    acc_bank #(.SIZE(8), .DEPTH(4), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    acc_bank #(.SIZE(8), .DEPTH(4), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int tests;
    int fails;

    // reference model, index 0 = wrap instance, 1 = saturating instance
    int unsigned m_acc  [2][4];
    int unsigned m_carry[2];
    int unsigned m_zero [2];
    int unsigned m_left [2];
    int unsigned m_prod [2];
    int unsigned m_tgt  [2];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int s, input int unsigned obs, input int unsigned exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, s, obs, exp);
        end
    endtask

    task automatic model_edge(input int s, input bit v, input int unsigned o,
                              input int unsigned w, input int unsigned val);
        int unsigned a, r;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_acc[s][i] = 0;
            m_carry[s] = 0; m_zero[s] = 0; m_left[s] = 0;
            return;
        end
        if (m_left[s] > 0) begin
            m_left[s]--;
            if (m_left[s] == 0) begin
                m_acc[s][m_tgt[s]] = m_prod[s] % 256;
                m_carry[s] = (m_prod[s] / 256) != 0;
                m_zero[s]  = (m_prod[s] % 256) == 0;
            end
            return;
        end
        if (!v || o == 0) return;
        a = m_acc[s][w];
        case (o)
            1: r = val;
            2: begin
                r = a + val;
                m_carry[s] = r > 255;
                r = (s == 1 && r > 255) ? 255 : r % 256;
            end
            3: begin
                m_carry[s] = val > a;
                r = (s == 1 && val > a) ? 0 : (a + 256 - val) % 256;
            end
            4: r = a & val;
            5: r = a | val;
            6: r = a ^ val;
            default: begin
                m_prod[s] = a * val;
                m_tgt[s]  = w;
                m_left[s] = 8;
                return;
            end
        endcase
        m_acc[s][w] = r;
        m_zero[s] = (r == 0);
    endtask

    task automatic step(input bit v, input int unsigned o, input int unsigned w,
                        input int unsigned val, input int unsigned r);
        bus0.in_valid = v;           bus1.in_valid = v;
        bus0.op       = 3'(o);       bus1.op       = 3'(o);
        bus0.wr_sel   = 2'(w);       bus1.wr_sel   = 2'(w);
        bus0.in_val   = 8'(val);     bus1.in_val   = 8'(val);
        bus0.rd_sel   = 2'(r);       bus1.rd_sel   = 2'(r);
        @(posedge clk);
        model_edge(0, v, o, w, val);
        model_edge(1, v, o, w, val);
        #1;
        chk("out_val", 0, bus0.out_val,    m_acc[0][r]);
        chk("carry",   0, bus0.carry_flag, m_carry[0]);
        chk("zero",    0, bus0.zero_flag,  m_zero[0]);
        chk("busy",    0, bus0.busy,       m_left[0] > 0);
        chk("ready",   0, bus0.in_ready,   m_left[0] == 0);
        chk("out_val", 1, bus1.out_val,    m_acc[1][r]);
        chk("carry",   1, bus1.carry_flag, m_carry[1]);
        chk("zero",    1, bus1.zero_flag,  m_zero[1]);
        chk("busy",    1, bus1.busy,       m_left[1] > 0);
        chk("ready",   1, bus1.in_ready,   m_left[1] == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1, 0, 8'hAA, 0);
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        tests = 0;
        fails = 0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) m_acc[s][i] = 0;
            m_carry[s] = 0; m_zero[s] = 0; m_left[s] = 0; m_prod[s] = 0; m_tgt[s] = 0;
        end

        // reset beats a simultaneous LOAD; zero_flag clears despite all-zero accumulators
        do_reset();
        chk("rst_out", 0, bus0.out_val, 0);
        chk("rst_zero", 0, bus0.zero_flag, 0);
        chk("rst_ready", 0, bus0.in_ready, 1);

        // wrap add: 0x7F + 0x81
        step(1, 1, 1, 8'h7F, 1);
        chk("load_7f", 0, bus0.out_val, 8'h7F);
        step(1, 2, 1, 8'h81, 1);
        chk("add_wrap", 0, bus0.out_val, 8'h00);
        chk("add_carry", 0, bus0.carry_flag, 1);
        chk("add_zero", 0, bus0.zero_flag, 1);
        chk("add_sat", 1, bus1.out_val, 8'hFF);

        // saturating add/sub on acc2
        step(1, 1, 2, 8'hF0, 2);
        step(1, 2, 2, 8'h20, 2);
        chk("sat_add", 1, bus1.out_val, 8'hFF);
        chk("sat_add_c", 1, bus1.carry_flag, 1);
        step(1, 3, 2, 8'hFF, 2);
        chk("sat_sub1", 1, bus1.out_val, 8'h00);
        step(1, 3, 2, 8'h01, 2);
        chk("sat_sub2", 1, bus1.out_val, 8'h00);
        chk("sat_sub_c", 1, bus1.carry_flag, 1);
        chk("sat_sub_z", 1, bus1.zero_flag, 1);

        // no bypass: same-cycle read shows the old value at the accepting edge's cycle
        step(1, 1, 3, 8'h0D, 3);
        // MUL 0x0D*0x0B, then a LOAD held valid through the busy window
        step(1, 7, 3, 8'h0B, 3);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 8'h55, i % 4);
        chk("mul_res", 0, dut0.acc[3], 8'h8F);
        chk("mul_c0", 0, bus0.carry_flag, 0);
        chk("held_ignored", 0, dut0.acc[0], 8'h00);
        step(1, 1, 0, 8'h55, 0);
        chk("held_taken", 0, bus0.out_val, 8'h55);
        step(1, 7, 3, 8'h02, 3);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 3);
        chk("mul2_res", 0, bus0.out_val, 8'h1E);
        chk("mul2_c", 0, bus0.carry_flag, 1);

        // zero multiplier still takes full length
        step(1, 7, 1, 8'h00, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

        // reset on the 4th busy cycle aborts the multiply
        step(1, 1, 2, 8'h09, 2);
        step(1, 7, 2, 8'h09, 2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2);
        do_reset();
        chk("abort_busy", 0, bus0.busy, 0);
        chk("abort_acc", 0, bus0.out_val, 0);

        // random stream with rd_sel sweep
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 255), n % 4);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/acc_bank.md
ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 SHALL have parameter SIZE, default 8, accumulator/data width in bits (legal 2..32).
REQ-002 SHALL have parameter DEPTH, default 4, number of accumulator registers (power of two, 2..16).
REQ-003 SHALL have parameter SAT, default 0, 1 = ADD/SUB saturate (unsigned), 0 = wrap.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  command present.
REQ-007 SHALL have port in_ready  output  1  block can accept command.
REQ-008 SHALL have port op  input  3  opcode: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 MUL.
REQ-009 SHALL have port wr_sel  input  log2(DEPTH)  target accumulator of command.
REQ-010 SHALL have port in_val  input  SIZE  command operand.
REQ-011 SHALL have port rd_sel  input  log2(DEPTH)  accumulator shown on out_val.
REQ-012 SHALL have port out_val  output  SIZE  acc[rd_sel], combinational from registers.
REQ-013 SHALL have port carry_flag  output  1  carry/borrow/overflow of last arithmetic op.
REQ-014 SHALL have port zero_flag  output  1  result of last writing op equals 0.
REQ-015 SHALL have port busy  output  1  multi-cycle MUL in progress.

Function
REQ-016 Command SHALL be accepted only on a rising edge where in_valid && in_ready; fields sampled at that edge only.
REQ-017 in_ready SHALL equal !busy; commands presented while busy SHALL be ignored, not queued.
REQ-018 LOAD/ADD/SUB/AND/OR/XOR SHALL write acc[wr_sel] at the accepting edge; new value visible on out_val the following cycle (latency 1).
REQ-019 NOP SHALL change no accumulator and no flag.
REQ-020 ADD: result = acc+in_val mod 2^SIZE, carry_flag = bit SIZE of the SIZE+1-bit sum; SAT=1 clamps result to 2^SIZE-1 when carry.
REQ-021 SUB: result = acc-in_val mod 2^SIZE, carry_flag = 1 when in_val > acc (borrow); SAT=1 clamps result to 0 on borrow.
REQ-022 LOAD/AND/OR/XOR SHALL leave carry_flag unchanged.
REQ-023 zero_flag SHALL update on every writing op (incl. MUL) to (stored result == 0), after saturation.
REQ-024 FSM SHALL have states IDLE and MUL; IDLE->MUL on accepted MUL; MUL->IDLE after SIZE iteration cycles.
REQ-025 MUL SHALL latch multiplicand acc[wr_sel], multiplier in_val, target index at acceptance; iterative shift-add, one multiplier bit per cycle, LSB first.
REQ-026 busy SHALL be high for exactly SIZE cycles, from the cycle after acceptance; in_ready low for the same cycles.
REQ-027 MUL result (low SIZE bits of product) SHALL be written on the edge ending the last busy cycle; carry_flag = 1 iff high SIZE product bits nonzero; SAT has no effect on MUL.
REQ-028 During MUL, target accumulator SHALL hold its pre-MUL value and other accumulators remain readable/unchanged.
REQ-029 MUL with multiplicand or multiplier zero SHALL still take SIZE cycles.
REQ-030 rd_sel == wr_sel on the accepting edge SHALL show the old value that cycle, new value next cycle (no bypass).

Reset
REQ-031 rst high at a rising edge SHALL clear all accumulators, carry_flag, zero_flag to 0, FSM to IDLE, iteration counter to 0; after reset busy=0, in_ready=1, out_val=0.
REQ-032 rst SHALL take priority over any command in the same cycle; rst during MUL aborts it with no accumulator write.
REQ-033 zero_flag SHALL reset to 0 (not 1) despite all accumulators being 0.

Verification (SIZE=8, DEPTH=4, SAT=0 unless stated)
REQ-034 Reset, then LOAD acc1=0x7F, ADD 0x81 -> acc1=0x00, carry=1, zero=1; out_val (rd_sel=1) shows 0x7F then 0x00 one cycle after each edge.
REQ-035 SAT=1: LOAD acc2=0xF0, ADD 0x20 -> acc2=0xFF, carry=1; SUB 0xFF then SUB 0x01 -> 0x00 then 0x00, carry=1, zero=1.
REQ-036 LOAD acc3=0x0D, MUL 0x0B -> busy high exactly 8 cycles, in_ready low, acc3=0x8F after, carry=0; MUL 0x02 -> 0x1E, carry=1.
REQ-037 Commands (LOAD acc0=0x55) held valid during MUL -> ignored until in_ready returns; acc0 changes only after acceptance.
REQ-038 Assert rst on 4th busy cycle of MUL -> busy=0, in_ready=1, all accumulators and flags 0 next cycle; target not written.
REQ-039 Random command stream with rd_sel sweep vs reference model -> out_val, flags, busy match every cycle.
